fetch_pc_gen: RTL and testbench
===============================

# fetch_pc_gen

Parametrised program-counter generator for the IF stage. It holds the fetch PC and computes the sequential PC+4 internally. It selects among branch, register-jump and absolute-jump redirects, and supports pipeline stall. Control-hazard squash runs as a counted FLUSH window of configurable length, and a trap redirect overrides all other sources. It drives the instruction-memory address and a valid qualifier consumed by the IF/ID register.

## Interface
- WIDTH, 32: PC width in bits (≥ 8).
- RESET_VEC, 0: PC value loaded on reset (word aligned).
- TRAP_VEC, 32'h0000_0080: PC value loaded on trap (word aligned, truncated to WIDTH).
- FLUSH_CYCLES, 3: length of the squash window in cycles (1..15).

- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- en  in  1  advance enable; 0 = stall, PC held.
- pc_sel  in  2  00 = PC+4, 01 = branch_tgt, 10 = jr_tgt, 11 = jal_tgt.
- branch_tgt  in  WIDTH  branch target.
- jr_tgt  in  WIDTH  register-jump target.
- jal_tgt  in  WIDTH  absolute-jump target.
- flush  in  1  start or restart squash window (single-cycle pulse or level).
- trap  in  1  redirect to TRAP_VEC.
- pc_if  out  WIDTH  current fetch PC (registered).
- pc_valid  out  1  fetch at pc_if is architecturally valid.
- flushing  out  1  FLUSH state active (combinational from state and flush).
- misaligned  out  1  registered flag: the previous taken redirect target had bits[1:0] ≠ 0.

## Operation
- Two states:
  - RUN: normal sequencing.
  - FLUSH: squash window, with 4-bit down-counter cnt.
- Per-edge priority, highest first:
  - RST: pc ← RESET_VEC, state ← RUN, cnt ← 0, misaligned ← 0.
  - trap: pc ← TRAP_VEC, state ← RUN, cnt ← 0. Ignores en, flush and state.
  - flush (any state): state ← FLUSH, cnt ← FLUSH_CYCLES−1, pc held. flush in FLUSH restarts the window.
  - In FLUSH: pc held. If cnt == 0, state ← RUN; else cnt ← cnt−1. Counts even when en = 0.
  - In RUN with en = 1: pc ← selected source.
  - In RUN with en = 0: pc held.
- Redirect targets are loaded with bits[1:0] forced to 00. misaligned is set to 1 on the edge that loads a target whose raw bits[1:0] ≠ 0. It is cleared on the next PC update from any source.
- PC+4 is computed modulo 2^WIDTH. All-ones-aligned wraps to 0 with no flag.
- Outputs:
  - pc_valid = (state == RUN) && !flush.
  - flushing = (state == FLUSH) || flush.

## Timing
- Reset values: pc_if = RESET_VEC, pc_valid = 1, flushing = 0, misaligned = 0.
- Redirect latency: source sampled at edge t, pc_if shows it in cycle t+1.
- Flush asserted in cycle t:
  - Suppresses the pc update at edge t.
  - pc_valid goes low in cycle t (combinational).
  - pc_valid stays low for cycles t .. t+FLUSH_CYCLES.
  - pc_valid returns to 1 in cycle t+FLUSH_CYCLES+1.
  - The first pc update after the window happens at the edge ending cycle t+FLUSH_CYCLES+1.
- Trap in cycle t: pc_if = TRAP_VEC and pc_valid = 1 in cycle t+1, even mid-FLUSH.
- Trap and flush in the same cycle: trap wins. flush is ignored that cycle.
- RST mid-FLUSH aborts the window. The next cycle is RUN with RESET_VEC.
- Stall has no effect on cnt or on trap.

## Test plan
- Reset then en = 1, pc_sel = 00 for 4 cycles: pc_if = 0, 4, 8, 12. pc_valid = 1 throughout.
- At pc = 8, pc_sel = 01, branch_tgt = 0x100: next pc_if = 0x100. Then branch_tgt = 0x203: pc_if = 0x200 and misaligned = 1 for one cycle, cleared after the next PC+4.
- FLUSH_CYCLES = 3, flush pulse at cycle t with pc = 0x40:
  - pc_valid = 0 for cycles t..t+3 and pc_if holds 0x40.
  - pc_valid = 1 at t+4.
  - pc_if = 0x44 at t+5.
  - Second flush at t+2: window extends so pc_valid = 0 through t+5.
- Trap during FLUSH at t+1: pc_if = 0x80 and pc_valid = 1 at t+2. Trap and flush together: same result, no FLUSH entry.
- en = 0 for 5 cycles with pc_sel = 11, jal_tgt = 0x300: pc_if frozen. On en = 1, pc_if = 0x300 the next cycle.
- WIDTH = 8, pc = 0xFC, PC+4: pc_if = 0x00. RST asserted mid-FLUSH: pc_if = RESET_VEC, pc_valid = 1 the next cycle.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// Fetch-PC generator bus: the redirect/control inputs from the pipeline and the
// fetch address outputs consumed by the IF/ID register.
interface fetch_pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic [1:0]       pc_sel;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jr_tgt;
  logic [WIDTH-1:0] jal_tgt;
  logic             flush;
  logic             trap;
  logic [WIDTH-1:0] pc_if;
  logic             pc_valid;
  logic             flushing;
  logic             misaligned;

  modport master (
    output en, pc_sel, branch_tgt, jr_tgt, jal_tgt, flush, trap,
    input  pc_if, pc_valid, flushing, misaligned
  );

  modport slave (
    input  en, pc_sel, branch_tgt, jr_tgt, jal_tgt, flush, trap,
    output pc_if, pc_valid, flushing, misaligned
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// IF-stage program-counter generator: sequential/branch/jump selection, stall,
// counted squash window after a control hazard, and trap redirect.
module fetch_pc_gen #(
  parameter int                   WIDTH        = 32,
  parameter logic [WIDTH-1:0]     RESET_VEC    = '0,
  parameter logic [31:0]          TRAP_VEC     = 32'h0000_0080,
  parameter int                   FLUSH_CYCLES = 3
) (
  input  logic                CLK,
  input  logic                RST,
  fetch_pc_gen_if.slave       bus
);

  localparam logic [WIDTH-1:0] TRAP_PC  = WIDTH'(TRAP_VEC) & ~WIDTH'(3);
  localparam logic [3:0]       CNT_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             misaligned_q, misaligned_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] tgt_aligned;

  // Wraps naturally modulo 2^WIDTH.
  assign pc_plus4 = pc_q + WIDTH'(4);

  always_comb begin
    raw_tgt = bus.branch_tgt;
    unique case (bus.pc_sel)
      2'b01:   raw_tgt = bus.branch_tgt;
      2'b10:   raw_tgt = bus.jr_tgt;
      2'b11:   raw_tgt = bus.jal_tgt;
      default: raw_tgt = pc_plus4;
    endcase
  end

  // Redirect targets are forced word-aligned; the dropped bits feed misaligned.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_align
      if (gi < 2) begin : g_lo
        assign tgt_aligned[gi] = 1'b0;
      end else begin : g_hi
        assign tgt_aligned[gi] = raw_tgt[gi];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      pc_q         <= RESET_VEC;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    misaligned_d = misaligned_q;

    if (bus.trap) begin
      state_d      = S_RUN;
      cnt_d        = '0;
      pc_d         = TRAP_PC;
      misaligned_d = 1'b0;
    end else if (bus.flush) begin
      // Also restarts an already running window.
      state_d = S_FLUSH;
      cnt_d   = CNT_INIT;
    end else if (state_q == S_FLUSH) begin
      // The window drains regardless of stall.
      if (cnt_q == 4'd0) begin
        state_d = S_RUN;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (bus.en) begin
      if (bus.pc_sel == 2'b00) begin
        pc_d         = pc_plus4;
        misaligned_d = 1'b0;
      end else begin
        pc_d         = tgt_aligned;
        misaligned_d = |raw_tgt[1:0];
      end
    end
  end

  assign bus.pc_if      = pc_q;
  assign bus.pc_valid   = (state_q == S_RUN) && !bus.flush;
  assign bus.flushing   = (state_q == S_FLUSH) || bus.flush;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: a default 32-bit instance and an 8-bit
// instance for PC wraparound, with hand-computed expectations.
module tb_fetch_pc_gen;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  fetch_pc_gen_if #(.WIDTH(32)) bus_a ();
  fetch_pc_gen_if #(.WIDTH(8))  bus_b ();

  fetch_pc_gen #(.WIDTH(32)) u_dut32 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_a)
  );

  fetch_pc_gen #(.WIDTH(8), .RESET_VEC(8'h00), .TRAP_VEC(32'h0000_0080), .FLUSH_CYCLES(3)) u_dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one cycle; inputs are then changed at #1 and sampled at #2.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus_a.en = 1'b0; bus_a.pc_sel = 2'b00; bus_a.flush = 1'b0; bus_a.trap = 1'b0;
    bus_a.branch_tgt = '0; bus_a.jr_tgt = '0; bus_a.jal_tgt = '0;
    bus_b.en = 1'b0; bus_b.pc_sel = 2'b00; bus_b.flush = 1'b0; bus_b.trap = 1'b0;
    bus_b.branch_tgt = '0; bus_b.jr_tgt = '0; bus_b.jal_tgt = '0;
    tick(); tick();
    RST = 1'b0;
    settle();
    check_eq("reset pc_if", bus_a.pc_if, 32'h0);
    check_eq("reset pc_valid", 32'(bus_a.pc_valid), 32'd1);
    check_eq("reset flushing", 32'(bus_a.flushing), 32'd0);
    check_eq("reset misaligned", 32'(bus_a.misaligned), 32'd0);

    // Sequential fetch
    bus_a.en = 1'b1; bus_a.pc_sel = 2'b00;
    settle(); check_eq("seq pc0", bus_a.pc_if, 32'h0);
    tick(); settle(); check_eq("seq pc4", bus_a.pc_if, 32'h4);
    tick(); settle(); check_eq("seq pc8", bus_a.pc_if, 32'h8);
    check_eq("seq valid", 32'(bus_a.pc_valid), 32'd1);

    // Branch redirects, aligned then misaligned
    bus_a.pc_sel = 2'b01; bus_a.branch_tgt = 32'h100;
    tick(); settle(); check_eq("branch 0x100", bus_a.pc_if, 32'h100);
    check_eq("branch aligned mis", 32'(bus_a.misaligned), 32'd0);
    bus_a.branch_tgt = 32'h203;
    tick(); settle(); check_eq("branch 0x203 pc", bus_a.pc_if, 32'h200);
    check_eq("branch 0x203 mis", 32'(bus_a.misaligned), 32'd1);
    bus_a.pc_sel = 2'b00;
    tick(); settle(); check_eq("seq after mis pc", bus_a.pc_if, 32'h204);
    check_eq("seq after mis mis", 32'(bus_a.misaligned), 32'd0);

    // Register jump, misaligned
    bus_a.pc_sel = 2'b10; bus_a.jr_tgt = 32'h1F2;
    tick(); settle(); check_eq("jr pc", bus_a.pc_if, 32'h1F0);
    check_eq("jr mis", 32'(bus_a.misaligned), 32'd1);

    // Reach 0x40 via jal, then flush window
    bus_a.pc_sel = 2'b11; bus_a.jal_tgt = 32'h40;
    tick(); bus_a.pc_sel = 2'b00;
    bus_a.flush = 1'b1; settle();              // cycle t
    check_eq("flush t pc", bus_a.pc_if, 32'h40);
    check_eq("flush t valid", 32'(bus_a.pc_valid), 32'd0);
    check_eq("flush t flushing", 32'(bus_a.flushing), 32'd1);
    tick(); bus_a.flush = 1'b0; settle();      // t+1
    check_eq("flush t+1 valid", 32'(bus_a.pc_valid), 32'd0);
    tick(); settle();                          // t+2
    check_eq("flush t+2 valid", 32'(bus_a.pc_valid), 32'd0);
    tick(); settle();                          // t+3
    check_eq("flush t+3 valid", 32'(bus_a.pc_valid), 32'd0);
    check_eq("flush t+3 pc", bus_a.pc_if, 32'h40);
    tick(); settle();                          // t+4
    check_eq("flush t+4 valid", 32'(bus_a.pc_valid), 32'd1);
    check_eq("flush t+4 pc", bus_a.pc_if, 32'h40);
    tick(); settle();                          // t+5
    check_eq("flush t+5 pc", bus_a.pc_if, 32'h44);

    // Restarted window: flush at t and t+2 keeps pc_valid low through t+5
    bus_a.flush = 1'b1; settle();              // t
    tick(); bus_a.flush = 1'b0; settle();      // t+1
    tick(); bus_a.flush = 1'b1; settle();      // t+2
    check_eq("reflush t+2 valid", 32'(bus_a.pc_valid), 32'd0);
    tick(); bus_a.flush = 1'b0; settle();      // t+3
    tick(); settle();                          // t+4
    check_eq("reflush t+4 valid", 32'(bus_a.pc_valid), 32'd0);
    tick(); settle();                          // t+5
    check_eq("reflush t+5 valid", 32'(bus_a.pc_valid), 32'd0);
    check_eq("reflush t+5 flushing", 32'(bus_a.flushing), 32'd1);
    tick(); settle();                          // t+6
    check_eq("reflush t+6 valid", 32'(bus_a.pc_valid), 32'd1);
    check_eq("reflush t+6 pc", bus_a.pc_if, 32'h44);
    tick(); settle();
    check_eq("reflush resume pc", bus_a.pc_if, 32'h48);

    // Trap mid-FLUSH
    bus_a.flush = 1'b1; settle();              // t
    tick(); bus_a.flush = 1'b0; bus_a.trap = 1'b1; settle();  // t+1
    check_eq("trap midflush flushing", 32'(bus_a.flushing), 32'd1);
    tick(); bus_a.trap = 1'b0; settle();       // t+2
    check_eq("trap midflush pc", bus_a.pc_if, 32'h80);
    check_eq("trap midflush valid", 32'(bus_a.pc_valid), 32'd1);
    tick(); settle();
    check_eq("trap resume pc", bus_a.pc_if, 32'h84);

    // Trap and flush together: trap wins, no FLUSH entry
    bus_a.flush = 1'b1; bus_a.trap = 1'b1;
    tick(); bus_a.flush = 1'b0; bus_a.trap = 1'b0; settle();
    check_eq("trap+flush pc", bus_a.pc_if, 32'h80);
    check_eq("trap+flush valid", 32'(bus_a.pc_valid), 32'd1);
    check_eq("trap+flush flushing", 32'(bus_a.flushing), 32'd0);
    tick(); settle();
    check_eq("trap+flush resume", bus_a.pc_if, 32'h84);

    // Stall with jal selected
    bus_a.en = 1'b0; bus_a.pc_sel = 2'b11; bus_a.jal_tgt = 32'h300;
    for (int i = 0; i < 5; i++) tick();
    settle(); check_eq("stall pc frozen", bus_a.pc_if, 32'h84);
    bus_a.en = 1'b1;
    tick(); settle(); check_eq("stall release jal", bus_a.pc_if, 32'h300);

    // RST mid-FLUSH
    bus_a.pc_sel = 2'b00;
    bus_a.flush = 1'b1;
    tick(); bus_a.flush = 1'b0;
    tick(); RST = 1'b1;
    tick(); RST = 1'b0; settle();
    check_eq("rst midflush pc", bus_a.pc_if, 32'h0);
    check_eq("rst midflush valid", 32'(bus_a.pc_valid), 32'd1);
    check_eq("rst midflush flushing", 32'(bus_a.flushing), 32'd0);

    // 8-bit instance: wrap from 0xFC to 0x00, then trap vector truncation
    check_eq("w8 reset pc", 32'(bus_b.pc_if), 32'h0);
    bus_b.en = 1'b1; bus_b.pc_sel = 2'b11; bus_b.jal_tgt = 8'hFC;
    tick(); bus_b.pc_sel = 2'b00; settle();
    check_eq("w8 jal 0xFC", 32'(bus_b.pc_if), 32'hFC);
    tick(); settle();
    check_eq("w8 wrap pc", 32'(bus_b.pc_if), 32'h00);
    check_eq("w8 wrap mis", 32'(bus_b.misaligned), 32'd0);
    bus_b.trap = 1'b1;
    tick(); bus_b.trap = 1'b0; settle();
    check_eq("w8 trap pc", 32'(bus_b.pc_if), 32'h80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
